// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 16-bit TSC datapath.
// Sequences fetch/decode/execute/memory/writeback, drives every mux and enable, and counts retired instructions.
module mc_control_unit #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic [1:0]           ALU_Compare,
    input  logic                 mem_ready,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [1:0]           RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUOp,
    output logic [1:0]           PCSource,
    output logic                 PC_en,
    output logic                 IorD,
    output logic [1:0]           MemtoReg,
    output logic                 output_active,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] num_inst
);

    typedef enum logic [3:0] {
        S_IF, S_DEC, S_EX, S_BR_TGT, S_BR_SET, S_MEM, S_WB, S_PCUP, S_JUMP, S_OUT, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_ORR = 4'd3;
    localparam logic [3:0] ALU_LHI = 4'd8;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_taken;
    logic [CNT_WIDTH-1:0]   r_num_inst;

    logic [3:0] w_opcode;
    logic [5:0] w_func;
    logic       w_is_rtype, w_is_ralu, w_is_imm_alu, w_is_branch, w_is_lwd, w_is_swd;
    logic       w_is_jmp, w_is_jal, w_is_jpr, w_is_jrl, w_is_wwd, w_is_hlt;
    logic       w_is_jump, w_is_link, w_to_ex, w_branch_taken;
    logic [3:0] w_imm_aluop;
    logic       w_unused;

    assign w_opcode     = instruction[15:12];
    assign w_func       = instruction[5:0];
    assign w_unused     = ^instruction[11:6];

    assign w_is_rtype   = (w_opcode == OP_RTYPE);
    assign w_is_ralu    = w_is_rtype && (w_func[5:3] == 3'd0);
    assign w_is_imm_alu = (w_opcode == OP_ADI) || (w_opcode == OP_ORI) || (w_opcode == OP_LHI);
    assign w_is_branch  = (w_opcode[3:2] == 2'b00);
    assign w_is_lwd     = (w_opcode == OP_LWD);
    assign w_is_swd     = (w_opcode == OP_SWD);
    assign w_is_jmp     = (w_opcode == OP_JMP);
    assign w_is_jal     = (w_opcode == OP_JAL);
    assign w_is_jpr     = w_is_rtype && (w_func == FN_JPR);
    assign w_is_jrl     = w_is_rtype && (w_func == FN_JRL);
    assign w_is_wwd     = w_is_rtype && (w_func == FN_WWD);
    assign w_is_hlt     = w_is_rtype && (w_func == FN_HLT);
    assign w_is_jump    = w_is_jmp || w_is_jal || w_is_jpr || w_is_jrl;
    assign w_is_link    = w_is_jal || w_is_jrl;
    assign w_to_ex      = w_is_ralu || w_is_imm_alu || w_is_lwd || w_is_swd || w_is_branch;

    assign w_imm_aluop  = (w_opcode == OP_ORI) ? ALU_ORR :
                          (w_opcode == OP_LHI) ? ALU_LHI : ALU_ADD;

    // Branch condition evaluated from the comparator during EX, held for BR_TGT.
    always_comb begin
        w_branch_taken = 1'b0;
        case (w_opcode[1:0])
            2'd0:    w_branch_taken = (ALU_Compare != 2'b00);
            2'd1:    w_branch_taken = (ALU_Compare == 2'b00);
            2'd2:    w_branch_taken = (ALU_Compare == 2'b01);
            default: w_branch_taken = (ALU_Compare == 2'b10);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IF;
            r_taken    <= 1'b0;
            r_num_inst <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_EX && w_is_branch) begin
                r_taken <= w_branch_taken;
            end
            if (w_state_next == S_IF && r_state != S_IF) begin
                r_num_inst <= r_num_inst + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        RegDst        = 2'd0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'd0;
        ALUOp         = ALU_ADD;
        PCSource      = 2'd0;
        PC_en         = 1'b0;
        IorD          = 1'b0;
        MemtoReg      = 2'd0;
        output_active = 1'b0;

        case (r_state)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    w_state_next = S_DEC;
                end
            end
            S_DEC: begin
                ALUSrcB = 2'd1;
                if (w_is_link) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd2;
                    MemtoReg = 2'd2;
                end
                if (w_is_jump)      w_state_next = S_JUMP;
                else if (w_is_hlt)  w_state_next = S_HALT;
                else if (w_is_wwd)  w_state_next = S_OUT;
                else if (w_to_ex)   w_state_next = S_EX;
                else                w_state_next = S_PCUP;
            end
            S_EX: begin
                ALUSrcA = 1'b1;
                if (w_is_ralu) begin
                    ALUOp        = {1'b0, w_func[2:0]};
                    w_state_next = S_WB;
                end else if (w_is_imm_alu) begin
                    ALUSrcB      = 2'd2;
                    ALUOp        = w_imm_aluop;
                    w_state_next = S_WB;
                end else if (w_is_lwd || w_is_swd) begin
                    ALUSrcB      = 2'd2;
                    w_state_next = S_MEM;
                end else if (w_is_branch) begin
                    ALUOp        = ALU_SUB;
                    ALUSrcB      = w_opcode[1] ? 2'd3 : 2'd0;
                    w_state_next = S_BR_TGT;
                end else begin
                    w_state_next = S_PCUP;
                end
            end
            S_BR_TGT: begin
                ALUSrcB      = 2'd2;
                w_state_next = r_taken ? S_BR_SET : S_PCUP;
            end
            S_BR_SET: begin
                PCSource     = 2'd1;
                PC_en        = 1'b1;
                w_state_next = S_PCUP;
            end
            S_MEM: begin
                // Address stays rs+imm: ALU_out reloads every cycle while we wait.
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                IorD    = 1'b1;
                if (w_is_lwd) begin
                    mem_read = 1'b1;
                    if (mem_ready) w_state_next = S_WB;
                end else begin
                    mem_write = 1'b1;
                    if (mem_ready) w_state_next = S_PCUP;
                end
            end
            S_WB: begin
                RegWrite     = 1'b1;
                RegDst       = w_is_rtype ? 2'd1 : 2'd0;
                MemtoReg     = w_is_lwd ? 2'd1 : 2'd0;
                ALUSrcB      = 2'd1;
                PC_en        = 1'b1;
                w_state_next = S_IF;
            end
            S_PCUP: begin
                ALUSrcB      = 2'd1;
                PC_en        = 1'b1;
                w_state_next = S_IF;
            end
            S_OUT: begin
                output_active = 1'b1;
                ALUSrcB       = 2'd1;
                PC_en         = 1'b1;
                w_state_next  = S_IF;
            end
            S_JUMP: begin
                PC_en        = 1'b1;
                PCSource     = (w_is_jmp || w_is_jal) ? 2'd3 : 2'd2;
                w_state_next = S_IF;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IF;
            end
        endcase

        // Reset aborts at once: nothing may be written or requested in that cycle.
        if (reset) begin
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            RegWrite      = 1'b0;
            PC_en         = 1'b0;
            output_active = 1'b0;
        end
    end

    assign is_halted = (r_state == S_HALT);
    assign num_inst  = r_num_inst;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed cycle-by-cycle bench for mc_control_unit: every cycle compares the full control word and num_inst
// against hand-computed values for the expected FSM state.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic [1:0]  ALU_Compare;
    logic        mem_ready;
    logic        ir_write, mem_read, mem_write, RegWrite, ALUSrcA, PC_en, IorD, output_active, is_halted;
    logic [1:0]  RegDst, ALUSrcB, PCSource, MemtoReg;
    logic [3:0]  ALUOp;
    logic [15:0] num_inst;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.WORD_SIZE(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .ALU_Compare(ALU_Compare),
        .mem_ready(mem_ready), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .PC_en(PC_en), .IorD(IorD), .MemtoReg(MemtoReg),
        .output_active(output_active), .is_halted(is_halted), .num_inst(num_inst)
    );

    logic [20:0] obs_cw;
    assign obs_cw = {ir_write, mem_read, mem_write, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, PC_en, IorD, MemtoReg, output_active, is_halted};

    function automatic logic [20:0] ecw(input int ir, input int mr, input int mw, input int rd, input int rw,
                                        input int asa, input int asb, input int op, input int pcs,
                                        input int pce, input int iord, input int m2r, input int oa,
                                        input int hlt);
        return {1'(ir), 1'(mr), 1'(mw), 2'(rd), 1'(rw), 1'(asa), 2'(asb), 4'(op),
                2'(pcs), 1'(pce), 1'(iord), 2'(m2r), 1'(oa), 1'(hlt)};
    endfunction

    // One clock cycle: apply inputs, compare outputs mid-cycle, then advance past the next edge.
    task automatic cyc(input string tag, input int rdy, input int cmp, input logic [20:0] exp_cw,
                       input int exp_cnt);
        mem_ready   = 1'(rdy);
        ALU_Compare = 2'(cmp);
        #1;
        n_checks++;
        assert (obs_cw === exp_cw) else begin
            n_errors++;
            $error("FAIL %s ctrl: observed %h expected %h", tag, obs_cw, exp_cw);
        end
        n_checks++;
        assert (num_inst === 16'(exp_cnt)) else begin
            n_errors++;
            $error("FAIL %s num_inst: observed %0d expected %0d", tag, num_inst, exp_cnt);
        end
        $display("cycle %-10s ctrl=%h num_inst=%0d", tag, obs_cw, num_inst);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [20:0] CW_Z, CW_IFW, CW_IFR, CW_DEC, CW_PCUP, CW_WB_R, CW_WB_I, CW_WB_L;
        logic [20:0] CW_EX_M, CW_MEM_R, CW_MEM_W, CW_BRT, CW_BRS, CW_HLT;
        CW_Z     = ecw(0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0);
        CW_IFW   = ecw(0,1,0, 0,0, 0,0,0, 0,0,0,0, 0,0);
        CW_IFR   = ecw(1,1,0, 0,0, 0,0,0, 0,0,0,0, 0,0);
        CW_DEC   = ecw(0,0,0, 0,0, 0,1,0, 0,0,0,0, 0,0);
        CW_PCUP  = ecw(0,0,0, 0,0, 0,1,0, 0,1,0,0, 0,0);
        CW_WB_R  = ecw(0,0,0, 1,1, 0,1,0, 0,1,0,0, 0,0);
        CW_WB_I  = ecw(0,0,0, 0,1, 0,1,0, 0,1,0,0, 0,0);
        CW_WB_L  = ecw(0,0,0, 0,1, 0,1,0, 0,1,0,1, 0,0);
        CW_EX_M  = ecw(0,0,0, 0,0, 1,2,0, 0,0,0,0, 0,0);
        CW_MEM_R = ecw(0,1,0, 0,0, 1,2,0, 0,0,1,0, 0,0);
        CW_MEM_W = ecw(0,0,1, 0,0, 1,2,0, 0,0,1,0, 0,0);
        CW_BRT   = ecw(0,0,0, 0,0, 0,2,0, 0,0,0,0, 0,0);
        CW_BRS   = ecw(0,0,0, 0,0, 0,0,0, 1,1,0,0, 0,0);
        CW_HLT   = ecw(0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,1);

        reset = 1'b1; instruction = 16'h0000; ALU_Compare = 2'b00; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("RST", 1, 0, CW_Z, 0);
        reset = 1'b0;

        instruction = 16'hF6C0;  // ADD $3,$1,$2
        cyc("ADD.IF",  1, 0, CW_IFR, 0);
        cyc("ADD.DEC", 1, 0, CW_DEC, 0);
        cyc("ADD.EX",  1, 0, ecw(0,0,0, 0,0, 1,0,0, 0,0,0,0, 0,0), 0);
        cyc("ADD.WB",  1, 0, CW_WB_R, 0);

        instruction = 16'hF6C2;  // AND, fetch waits two cycles
        cyc("AND.IFW1", 0, 0, CW_IFW, 1);
        cyc("AND.IFW2", 0, 0, CW_IFW, 1);
        cyc("AND.IF",   1, 0, CW_IFR, 1);
        cyc("AND.DEC",  1, 0, CW_DEC, 1);
        cyc("AND.EX",   1, 0, ecw(0,0,0, 0,0, 1,0,2, 0,0,0,0, 0,0), 1);
        cyc("AND.WB",   1, 0, CW_WB_R, 1);

        instruction = 16'h5123;  // ORI
        cyc("ORI.IF",  1, 0, CW_IFR, 2);
        cyc("ORI.DEC", 1, 0, CW_DEC, 2);
        cyc("ORI.EX",  1, 0, ecw(0,0,0, 0,0, 1,2,3, 0,0,0,0, 0,0), 2);
        cyc("ORI.WB",  1, 0, CW_WB_I, 2);

        instruction = 16'h7105;  // LWD, memory ready after 3 wait cycles
        cyc("LWD.IF",   1, 0, CW_IFR, 3);
        cyc("LWD.DEC",  1, 0, CW_DEC, 3);
        cyc("LWD.EX",   1, 0, CW_EX_M, 3);
        cyc("LWD.MEMW1", 0, 0, CW_MEM_R, 3);
        cyc("LWD.MEMW2", 0, 0, CW_MEM_R, 3);
        cyc("LWD.MEMW3", 0, 0, CW_MEM_R, 3);
        cyc("LWD.MEM",  1, 0, CW_MEM_R, 3);
        cyc("LWD.WB",   1, 0, CW_WB_L, 3);

        instruction = 16'h8105;  // SWD, zero-wait
        cyc("SWD.IF",   1, 0, CW_IFR, 4);
        cyc("SWD.DEC",  1, 0, CW_DEC, 4);
        cyc("SWD.EX",   1, 0, CW_EX_M, 4);
        cyc("SWD.MEM",  1, 0, CW_MEM_W, 4);
        cyc("SWD.PCUP", 1, 0, CW_PCUP, 4);

        instruction = 16'h1203;  // BEQ taken; compare changes after EX must not matter
        cyc("BEQT.IF",  1, 0, CW_IFR, 5);
        cyc("BEQT.DEC", 1, 0, CW_DEC, 5);
        cyc("BEQT.EX",  1, 0, ecw(0,0,0, 0,0, 1,0,1, 0,0,0,0, 0,0), 5);
        cyc("BEQT.TGT", 1, 1, CW_BRT, 5);
        cyc("BEQT.SET", 1, 1, CW_BRS, 5);
        cyc("BEQT.PCUP", 1, 1, CW_PCUP, 5);

        cyc("BEQN.IF",  1, 1, CW_IFR, 6);
        cyc("BEQN.DEC", 1, 1, CW_DEC, 6);
        cyc("BEQN.EX",  1, 1, ecw(0,0,0, 0,0, 1,0,1, 0,0,0,0, 0,0), 6);
        cyc("BEQN.TGT", 1, 0, CW_BRT, 6);
        cyc("BEQN.PCUP", 1, 0, CW_PCUP, 6);

        instruction = 16'h2203;  // BGZ taken (A>B)
        cyc("BGZ.IF",  1, 0, CW_IFR, 7);
        cyc("BGZ.DEC", 1, 0, CW_DEC, 7);
        cyc("BGZ.EX",  1, 1, ecw(0,0,0, 0,0, 1,3,1, 0,0,0,0, 0,0), 7);
        cyc("BGZ.TGT", 1, 0, CW_BRT, 7);
        cyc("BGZ.SET", 1, 0, CW_BRS, 7);
        cyc("BGZ.PCUP", 1, 0, CW_PCUP, 7);

        instruction = 16'hA010;  // JAL
        cyc("JAL.IF",   1, 0, CW_IFR, 8);
        cyc("JAL.DEC",  1, 0, ecw(0,0,0, 2,1, 0,1,0, 0,0,0,2, 0,0), 8);
        cyc("JAL.JUMP", 1, 0, ecw(0,0,0, 0,0, 0,0,0, 3,1,0,0, 0,0), 8);

        instruction = 16'hF019;  // JPR
        cyc("JPR.IF",   1, 0, CW_IFR, 9);
        cyc("JPR.DEC",  1, 0, CW_DEC, 9);
        cyc("JPR.JUMP", 1, 0, ecw(0,0,0, 0,0, 0,0,0, 2,1,0,0, 0,0), 9);

        instruction = 16'hF01C;  // WWD
        cyc("WWD.IF",  1, 0, CW_IFR, 10);
        cyc("WWD.DEC", 1, 0, CW_DEC, 10);
        cyc("WWD.OUT", 1, 0, ecw(0,0,0, 0,0, 0,1,0, 0,1,0,0, 1,0), 10);

        instruction = 16'hB000;  // undefined opcode
        cyc("UND.IF",   1, 0, CW_IFR, 11);
        cyc("UND.DEC",  1, 0, CW_DEC, 11);
        cyc("UND.PCUP", 1, 0, CW_PCUP, 11);

        instruction = 16'hF01D;  // HLT
        cyc("HLT.IF",  1, 0, CW_IFR, 12);
        cyc("HLT.DEC", 1, 0, CW_DEC, 12);
        for (int i = 0; i < 10; i++) begin
            cyc("HLT.HOLD", 1, 0, CW_HLT, 12);
        end

        reset = 1'b1;
        cyc("HLT.RST", 1, 0, CW_HLT, 12);
        reset = 1'b0;

        instruction = 16'h8105;  // SWD aborted by reset while waiting
        cyc("SWDA.IF",   1, 0, CW_IFR, 0);
        cyc("SWDA.DEC",  1, 0, CW_DEC, 0);
        cyc("SWDA.EX",   1, 0, CW_EX_M, 0);
        cyc("SWDA.MEMW1", 0, 0, CW_MEM_W, 0);
        cyc("SWDA.MEMW2", 0, 0, CW_MEM_W, 0);
        reset = 1'b1;
        cyc("SWDA.RST", 1, 0, ecw(0,0,0, 0,0, 1,2,0, 0,0,1,0, 0,0), 0);
        reset = 1'b0;
        cyc("SWDA.IF2", 0, 0, CW_IFW, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle FSM controller that sequences the 16-bit TSC datapath: fetch, decode, execute, memory and writeback, one instruction at a time.
- Drives every datapath mux/enable, runs the req/ready handshake with unified memory, and owns the instruction-register load.
- Raises halt status and counts retired instructions.

Parameters:
- WORD_SIZE, 16, instruction/data width
- CNT_WIDTH, 16, width of num_inst

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- instruction  in  16  IR contents; [15:12] opcode, [5:0] func
- ALU_Compare  in  2  from datapath: 00 A==B, 01 A>B signed, 10 A<B signed
- mem_ready  in  1  memory completes current request this cycle
- ir_write  out  1  load IR from memory data
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- RegDst  out  2  0 rt, 1 rd, 2 $2
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  0 PC, 1 rs
- ALUSrcB  out  2  0 rt, 1 const 1, 2 sign-ext imm, 3 zero
- ALUOp  out  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 NOT, 5 TCP, 6 SHL, 7 SHR, 8 LHI
- PCSource  out  2  0 ALU result, 1 ALU_out reg, 2 rs, 3 jump target
- PC_en  out  1  PC write enable
- IorD  out  1  0 address=PC, 1 address=ALU_out
- MemtoReg  out  2  0 ALU_out, 1 memory data, 2 PC+1
- output_active  out  1  drive rs onto output port (WWD)
- is_halted  out  1  HLT executed
- num_inst  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset: state IF; num_inst=0; is_halted=0. All enables (ir_write, mem_read, mem_write, RegWrite, PC_en, output_active) are 0 in any cycle with reset high. All mux selects default to 0 in every state unless listed below.
- States: IF, DEC, EX, BR_TGT, BR_SET, MEM, WB, PCUP, JUMP, OUT, HALT.
- Handshake: mem_read/mem_write held high until the edge at which mem_ready=1; zero-wait (ready in the first cycle) is legal. ALU inputs/op stay constant while waiting, because ALU_out reloads every cycle.
- IF:
  - mem_read=1, IorD=0.
  - On ready: ir_write=1 and go to DEC; otherwise stay in IF.
- DEC:
  - ALUSrcA=0, ALUSrcB=1, ADD.
  - JAL/JRL additionally write PC+1 to $2 (RegWrite=1, RegDst=2, MemtoReg=2).
  - Next state: JMP/JAL → JUMP; JPR/JRL → JUMP; HLT → HALT; WWD → OUT; undefined opcode/func → PCUP; all others → EX.
- EX:
  - R-ALU (op 15, func 0-7): ALUSrcA=1, ALUSrcB=0, ALUOp=func[2:0] → WB.
  - ADI/ORI/LHI (op 4/5/6): ALUSrcA=1, ALUSrcB=2, ALUOp ADD/ORR/LHI → WB.
  - LWD/SWD (op 7/8): ALUSrcA=1, ALUSrcB=2, ADD → MEM.
  - Branch (op 0-3): ALUSrcA=1, SUB, ALUSrcB=0 for BNE/BEQ and 3 for BGZ/BLZ. Latch taken flag: BNE Compare≠00, BEQ =00, BGZ =01, BLZ =10. → BR_TGT.
- BR_TGT: ALUSrcA=0, ALUSrcB=2, ADD (ALU_out←PC+imm). Taken → BR_SET; not taken → PCUP.
- BR_SET: PCSource=1, PC_en=1 → PCUP.
- MEM:
  - Hold EX ALU settings; IorD=1.
  - LWD: mem_read; on ready → WB.
  - SWD: mem_write; on ready → PCUP.
  - Memory holds read data until its next request.
- WB:
  - RegWrite=1. RegDst=1 for R-type, 0 otherwise. MemtoReg=1 for LWD, 0 otherwise.
  - Concurrently ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PC_en=1 → IF.
- PCUP: ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PC_en=1 → IF.
- OUT: output_active=1 for exactly one cycle, plus PCUP signals → IF.
- JUMP: PC_en=1; PCSource=3 for JMP/JAL, 2 for JPR/JRL → IF.
- HALT: is_halted=1, all enables 0; stays in HALT until reset.
- num_inst: increments by 1 on every transition into IF (except from reset); wraps modulo 2^CNT_WIDTH; HLT is not counted.
- Latencies (zero-wait memory), in cycles:
  - R/I-ALU 4; LWD 5; SWD 5; WWD 3; JMP/JAL/JPR/JRL 3; branch not-taken 5, taken 6.
- Reset mid-operation (including while waiting on mem_ready) aborts immediately; no PC_en/RegWrite is issued in the reset cycle.

Test Plan:
- ADD $3,$1,$2, ready immediate → IF,DEC,EX,WB in 4 cycles; WB: RegWrite=1, RegDst=1, MemtoReg=0, PC_en=1; num_inst 0→1.
- LWD with mem_ready delayed 3 cycles in MEM → mem_read=1, IorD=1 held 3 cycles with ALUSrcA=1, ALUSrcB=2 constant; WB: MemtoReg=1, RegDst=0; total 8 cycles.
- BEQ with Compare=00 → BR_SET asserts PCSource=1, PC_en=1, then PCUP; same BEQ with Compare=01 → BR_SET skipped, 5 cycles.
- JAL → DEC: RegWrite=1, RegDst=2, MemtoReg=2; JUMP: PCSource=3, PC_en=1; WWD → output_active high exactly 1 cycle.
- HLT → is_halted=1 and held through 10 cycles with all enables 0; num_inst unchanged.
- Assert reset during the SWD MEM wait → next cycle state IF, mem_write=0, num_inst=0, is_halted=0.
